fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline. Owns the PC register and drives the synchronous-read instruction BRAM.
- Selects next PC from reset vector, exception vector, EPC, D-stage branch/jump target, or PC+4.
- Detects fetch-address exceptions (AdEL).
- Produces F_PC, F_Instr, F_DelaySlot and F_EXCCode, which the IF/ID register latches.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_npc_sel.sv | 41 ++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants for the MIPS IF stage
//
// Purpose: reset/exception vectors, legal instruction-memory window and
//          exception codes shared by fetch_stage and fetch_stage_npc_sel.
// Ports:   none (package).
package fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI    = 32'h0000_6FFC;
  localparam int          DEF_IM_AW    = 12;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;

endpackage

// File: rtl/fetch_stage_npc_sel.sv
// rtl/fetch_stage_npc_sel.sv - next-PC priority mux
//
// Purpose: picks the next fetch PC. Priority, highest first:
//          reset, exception request, stall, eret, branch/jump redirect, PC+4.
// Ports:
//   i_reset     synchronous reset request -> RESET_PC
//   i_req       exception/interrupt taken -> EXC_VEC (beats stall)
//   i_stall     hold current PC
//   i_eret      eret in D -> i_epc
//   i_epc       forwarded EPC
//   i_redirect  branch taken / jump in D -> i_target
//   i_target    D-stage branch/jump target
//   i_pc        current PC
//   o_npc       selected next PC
module fetch_stage_npc_sel
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_stall,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  input  logic [31:0] i_pc,
  output logic [31:0] o_npc
);

  always_comb begin
    o_npc = i_pc + 32'd4;
    if (i_reset)         o_npc = RESET_PC;
    else if (i_req)      o_npc = EXC_VEC;
    else if (i_stall)    o_npc = i_pc;
    else if (i_eret)     o_npc = i_epc;
    else if (i_redirect) o_npc = i_target;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, BRAM address, AdEL detection
//
// Purpose: owns the PC, drives the synchronous-read instruction BRAM from the
//          next PC so the word for PC arrives one cycle later, and flags
//          fetch-address exceptions.
// Build option: PC_RANGE_CHECK_EN - when defined, a PC outside
//          [IM_LO, IM_HI] also raises AdEL; otherwise only misalignment does.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   stall         hazard stall (hold PC)
//   Req           exception/interrupt taken
//   D_eret        eret decoded in D
//   EPC           forwarded CP0 EPC
//   D_redirect    D-stage branch taken or jump
//   D_target      D-stage branch/jump target
//   D_is_jb       D-stage instruction is a branch/jump
//   im_addr       BRAM word address (combinational from next PC)
//   im_rdata      BRAM read data (one cycle after im_addr)
//   F_PC          current fetch PC
//   F_Instr       fetched instruction, 0 on fault
//   F_DelaySlot   F instruction sits in a delay slot
//   F_EXCCode     0 = none, 4 = AdEL
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
  parameter logic [31:0] IM_LO    = DEF_IM_LO,
  parameter int          IM_AW    = DEF_IM_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             Req,
  input  logic             D_eret,
  input  logic [31:0]      EPC,
  input  logic             D_redirect,
  input  logic [31:0]      D_target,
  input  logic             D_is_jb,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      F_PC,
  output logic [31:0]      F_Instr,
  output logic             F_DelaySlot,
  output logic [4:0]       F_EXCCode
);

  // Word offset of the bottom of the instruction window inside the BRAM
  // address space; subtracting it maps IM_LO to BRAM word 0.
  localparam logic [IM_AW-1:0] LO_WORD = IM_LO[IM_AW+1:2];

  logic [31:0] r_pc;
  logic [31:0] w_npc;
  logic        w_fault;

  fetch_stage_npc_sel #(
    .RESET_PC (RESET_PC),
    .EXC_VEC  (EXC_VEC)
  ) u_npc_sel (
    .i_reset    (reset),
    .i_req      (Req),
    .i_stall    (stall),
    .i_eret     (D_eret),
    .i_epc      (EPC),
    .i_redirect (D_redirect),
    .i_target   (D_target),
    .i_pc       (r_pc),
    .o_npc      (w_npc)
  );

  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_npc;
  end

  // Truncation to IM_AW bits keeps any out-of-window PC inside the BRAM.
  assign im_addr = w_npc[IM_AW+1:2] - LO_WORD;

`ifdef PC_RANGE_CHECK_EN
  assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > DEF_IM_HI);
`else
  assign w_fault = (r_pc[1:0] != 2'b00);
`endif

  assign F_PC        = r_pc;
  assign F_Instr     = w_fault ? 32'h0 : im_rdata;
  assign F_EXCCode   = w_fault ? EXC_ADEL : EXC_NONE;
  // eret has no delay slot, so its wrong-path fetch is never flagged.
  assign F_DelaySlot = D_is_jb & ~D_eret;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, Req, D_eret, D_redirect, D_is_jb;
  logic [31:0] EPC, D_target;
  logic [11:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] F_PC, F_Instr;
  logic        F_DelaySlot;
  logic [4:0]  F_EXCCode;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .Req         (Req),
    .D_eret      (D_eret),
    .EPC         (EPC),
    .D_redirect  (D_redirect),
    .D_target    (D_target),
    .D_is_jb     (D_is_jb),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .F_PC        (F_PC),
    .F_Instr     (F_Instr),
    .F_DelaySlot (F_DelaySlot),
    .F_EXCCode   (F_EXCCode)
  );

  // Synchronous-read instruction BRAM.
  always @(posedge clk) im_rdata <= mem[im_addr];

  // Reference model: architectural PC and what the F outputs must show for it.
  logic [31:0] m_pc;
  bit          m_valid = 0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - 32'h0000_3000) >> 2;
    return mem[off[11:0]];
  endfunction

  function automatic bit faulty(input logic [31:0] pc);
    bit f;
    f = (pc % 4) != 0;
`ifdef PC_RANGE_CHECK_EN
    if (pc < 32'h0000_3000 || pc > 32'h0000_6FFC) f = 1;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    if (reset)           m_pc = 32'h0000_3000;
    else if (Req)        m_pc = 32'h0000_4180;
    else if (stall)      m_pc = m_pc;
    else if (D_eret)     m_pc = EPC;
    else if (D_redirect) m_pc = D_target;
    else                 m_pc = m_pc + 32'd4;
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (F_PC !== m_pc) begin
        errors++;
        $display("FAIL model_pc: got %h want %h", F_PC, m_pc);
      end
      checks++;
      if (F_EXCCode !== (faulty(m_pc) ? 5'd4 : 5'd0)) begin
        errors++;
        $display("FAIL model_exc pc=%h: got %0d want %0d", m_pc, F_EXCCode, faulty(m_pc) ? 4 : 0);
      end
      checks++;
      if (F_Instr !== (faulty(m_pc) ? 32'h0 : word_at(m_pc))) begin
        errors++;
        $display("FAIL model_instr pc=%h: got %h want %h", m_pc, F_Instr,
                 faulty(m_pc) ? 32'h0 : word_at(m_pc));
      end
      checks++;
      if (F_DelaySlot !== (D_is_jb && !D_eret)) begin
        errors++;
        $display("FAIL model_ds: got %b want %b", F_DelaySlot, D_is_jb && !D_eret);
      end
    end
  end

  task automatic drive(input bit st, input bit rq, input bit er, input logic [31:0] epc,
                       input bit rd, input logic [31:0] tg, input bit jb);
    stall = st; Req = rq; D_eret = er; EPC = epc;
    D_redirect = rd; D_target = tg; D_is_jb = jb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    #1;
    lit("im_addr_in_reset", {20'h0, im_addr}, 32'h0);
    tick(); tick();
    lit("rst_pc", F_PC, 32'h3000);
    lit("rst_instr", F_Instr, 32'hA500_0000);
    lit("rst_exc", {27'h0, F_EXCCode}, 32'h0);

    reset = 1'b0;
    tick();
    lit("seq_pc1", F_PC, 32'h3004);
    lit("seq_instr1", F_Instr, 32'hA500_0001);
    tick();
    lit("seq_pc2", F_PC, 32'h3008);

    drive(0, 0, 0, 32'h0, 1, 32'h3100, 1);
    #1;
    lit("delay_slot_flag", {31'h0, F_DelaySlot}, 32'h1);
    lit("delay_slot_pc", F_PC, 32'h3008);
    tick();
    lit("branch_pc", F_PC, 32'h3100);
    lit("branch_instr", F_Instr, 32'hA500_0040);

    drive(0, 0, 0, 32'h0, 1, 32'h300C, 1);
    tick();
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("stall_pc", F_PC, 32'h300C);
      lit("stall_instr", F_Instr, 32'hA500_0003);
    end
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    lit("after_stall_pc", F_PC, 32'h3010);

    drive(0, 0, 0, 32'h0, 1, 32'h3020, 1);
    tick();
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    lit("req_over_stall_pc", F_PC, 32'h4180);
    lit("req_over_stall_instr", F_Instr, 32'hA500_0460);

    drive(0, 0, 1, 32'h3044, 0, 32'h0, 0);
    tick();
    lit("eret_pc", F_PC, 32'h3044);
    lit("eret_instr", F_Instr, 32'hA500_0011);
    drive(0, 1, 1, 32'h3044, 0, 32'h0, 0);
    tick();
    lit("req_over_eret", F_PC, 32'h4180);

    drive(0, 0, 1, 32'h3200, 1, 32'h3300, 1);
    #1;
    lit("eret_no_ds", {31'h0, F_DelaySlot}, 32'h0);
    tick();
    lit("eret_over_redirect", F_PC, 32'h3200);

    drive(0, 0, 0, 32'h0, 1, 32'h3102, 1);
    tick();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    lit("misalign_pc", F_PC, 32'h3102);
    lit("misalign_exc", {27'h0, F_EXCCode}, 32'h4);
    lit("misalign_instr", F_Instr, 32'h0);
    tick();

    drive(0, 0, 0, 32'h0, 1, 32'h7000, 1);
    tick();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
`ifdef PC_RANGE_CHECK_EN
    lit("range_exc", {27'h0, F_EXCCode}, 32'h4);
    lit("range_instr", F_Instr, 32'h0);
`else
    lit("range_exc", {27'h0, F_EXCCode}, 32'h0);
    lit("range_instr", F_Instr, 32'hA500_0000);
`endif
    tick();

    drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
    tick();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    lit("wrap_pc", F_PC, 32'h0000_0000);

    drive(1, 0, 0, 32'h0, 1, 32'h3400, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    lit("reset_mid_stall_pc", F_PC, 32'h3000);
    lit("reset_mid_stall_instr", F_Instr, 32'hA500_0000);
    tick(); tick();
    lit("post_reset_run", F_PC, 32'h3008);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
